// File: rtl/pwm_sequencer_pkg.sv
// Shared constants and types for the PWM sequencer and the SPI register map that feeds it.
package pwm_sequencer_pkg;

  localparam int unsigned PWM_CNT_W = 8;
  localparam int unsigned EN_W      = 16;
  localparam int unsigned DUTY_W    = 8;

  localparam logic [PWM_CNT_W-1:0] PWM_MAX   = 8'hFF;
  localparam logic [DUTY_W-1:0]    DUTY_FULL = 8'hFF;

  // SPI register indices; the register file packs these into the cfg bus.
  localparam logic [2:0] REG_EN_OUT_7_0  = 3'd0;
  localparam logic [2:0] REG_EN_OUT_15_8 = 3'd1;
  localparam logic [2:0] REG_EN_PWM_7_0  = 3'd2;
  localparam logic [2:0] REG_EN_PWM_15_8 = 3'd3;
  localparam logic [2:0] REG_DUTY        = 3'd4;

  typedef struct packed {
    logic [EN_W-1:0]   en_out;
    logic [EN_W-1:0]   en_pwm;
    logic [DUTY_W-1:0] duty;
  } pwm_cfg_t;

  // Full-scale duty is special-cased so the last count step does not drop out.
  function automatic logic pwm_level(input logic [DUTY_W-1:0] duty,
                                     input logic [PWM_CNT_W-1:0] cnt);
    return (duty == DUTY_FULL) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_sequencer_if.sv
// Config bus between the SPI register file (master) and the PWM sequencer (slave).
interface pwm_sequencer_if;
  import pwm_sequencer_pkg::*;

  logic              cfg_wr;
  logic [EN_W-1:0]   cfg_en_out;
  logic [EN_W-1:0]   cfg_en_pwm;
  logic [DUTY_W-1:0] cfg_duty;
  logic              cfg_pending;
  logic              cfg_applied;

  modport master (
    output cfg_wr, cfg_en_out, cfg_en_pwm, cfg_duty,
    input  cfg_pending, cfg_applied
  );

  modport slave (
    input  cfg_wr, cfg_en_out, cfg_en_pwm, cfg_duty,
    output cfg_pending, cfg_applied
  );

endinterface

// File: rtl/pwm_sequencer_prescaler.sv
// Divides clk into PWM count ticks; held at zero while run is low.
module pwm_sequencer_prescaler #(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic tick_o
);

  localparam int unsigned PreW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(CLK_DIV - 1);

  logic [PreW-1:0] pre_cnt_q, pre_cnt_d;

  assign tick_o = run_i & (pre_cnt_q == PreLast);

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (!run_i || tick_o) begin
      pre_cnt_d = '0;
    end else begin
      pre_cnt_d = pre_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/pwm_sequencer.sv
// 16-line PWM output stage with double-buffered config committed on period boundaries.
module pwm_sequencer
  import pwm_sequencer_pkg::*;
#(
  parameter int unsigned CLK_DIV = 13,
  parameter int unsigned NUM_OUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run_i,
  pwm_sequencer_if.slave       cfg_if,
  output logic [EN_W-1:0]      out_o,
  output logic                 period_start_o
);

  if (NUM_OUT != EN_W) begin : g_bad_num_out
    $error("pwm_sequencer supports exactly 16 outputs");
  end
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("pwm_sequencer CLK_DIV must be at least 1");
  end

  logic                 tick;
  logic                 boundary;
  logic [PWM_CNT_W-1:0] pwm_cnt_q, pwm_cnt_d;
  pwm_cfg_t             staged_q, staged_d;
  pwm_cfg_t             active_q, active_d;
  pwm_cfg_t             incoming;
  logic                 pending_q, pending_d;
  logic                 applied_q, applied_d;
  logic                 start_q;
  logic                 run_q;
  logic [EN_W-1:0]      out_q, out_d;
  logic [EN_W-1:0]      en_out_now;

  pwm_sequencer_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .run_i  (run_i),
    .tick_o (tick)
  );

  assign boundary = tick & (pwm_cnt_q == PWM_MAX);
  assign incoming = '{en_out: cfg_if.cfg_en_out, en_pwm: cfg_if.cfg_en_pwm,
                      duty: cfg_if.cfg_duty};

  always_comb begin
    pwm_cnt_d = pwm_cnt_q;
    if (!run_i) begin
      pwm_cnt_d = '0;
    end else if (tick) begin
      pwm_cnt_d = pwm_cnt_q + 1'b1;
    end
  end

  always_comb begin
    staged_d  = staged_q;
    active_d  = active_q;
    pending_d = pending_q;
    applied_d = 1'b0;
    if (cfg_if.cfg_wr && boundary) begin
      staged_d  = incoming;
      active_d  = incoming;
      pending_d = 1'b0;
      applied_d = 1'b1;
    end else begin
      if (pending_q && (boundary || !run_i)) begin
        active_d  = staged_q;
        pending_d = 1'b0;
        applied_d = 1'b1;
      end
      if (cfg_if.cfg_wr) begin
        staged_d  = incoming;
        pending_d = 1'b1;
        // Disables take effect at once; enables wait for the commit.
        active_d.en_out = active_d.en_out & incoming.en_out;
      end
    end
  end

  // Mask with an in-flight write so a disable reaches the pins on the very next cycle.
  always_comb begin
    en_out_now = active_q.en_out & (cfg_if.cfg_wr ? cfg_if.cfg_en_out : {EN_W{1'b1}});
    out_d      = '0;
    if (run_i) begin
      out_d = en_out_now &
              (~active_q.en_pwm | {EN_W{pwm_level(active_q.duty, pwm_cnt_q)}});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      staged_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      applied_q <= 1'b0;
      start_q   <= 1'b0;
      run_q     <= 1'b0;
      out_q     <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      staged_q  <= staged_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      applied_q <= applied_d;
      start_q   <= boundary;
      run_q     <= run_i;
      out_q     <= out_d;
    end
  end

  // The first run cycle already has both counters at zero, so it is a period start.
  assign period_start_o     = start_q | (run_i & ~run_q & ~rst);
  assign out_o              = out_q;
  assign cfg_if.cfg_pending = pending_q;
  assign cfg_if.cfg_applied = applied_q;

endmodule

// File: tb/tb_pwm_sequencer.sv
// Directed bench for pwm_sequencer with CLK_DIV=13 (3328-clk period).
module tb_pwm_sequencer;
  import pwm_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [15:0] out;
  logic        period_start;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          hi, lo;

  pwm_sequencer_if cfg_bus ();

  pwm_sequencer #(
    .CLK_DIV (13),
    .NUM_OUT (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .run_i          (run),
    .cfg_if         (cfg_bus),
    .out_o          (out),
    .period_start_o (period_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int target);
    while (cyc < target) step();
  endtask

  task automatic scan(input int target, input logic [15:0] exp, input string tag);
    int bad;
    bad = 0;
    while (cyc < target) begin
      step();
      if (out !== exp) bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  task automatic count_window(input int target, output int n_hi, output int n_lo);
    n_hi = 0;
    n_lo = 0;
    while (cyc < target) begin
      step();
      if (out === 16'hFFFF) n_hi++;
      if (out === 16'h0000) n_lo++;
    end
  endtask

  task automatic set_cfg(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    cfg_bus.cfg_wr     = 1'b1;
    cfg_bus.cfg_en_out = eo;
    cfg_bus.cfg_en_pwm = ep;
    cfg_bus.cfg_duty   = d;
  endtask

  task automatic pulse_cfg(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    set_cfg(eo, ep, d);
    step();
    cfg_bus.cfg_wr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    run = 1'b0;
    cfg_bus.cfg_wr     = 1'b0;
    cfg_bus.cfg_en_out = '0;
    cfg_bus.cfg_en_pwm = '0;
    cfg_bus.cfg_duty   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_out", 32'(out), 32'h0);
    check("rst_pstart", 32'(period_start), 32'h0);
    check("rst_pending", 32'(cfg_bus.cfg_pending), 32'h0);
    check("rst_applied", 32'(cfg_bus.cfg_applied), 32'h0);
    check("rst_pwm_cnt", 32'(dut.pwm_cnt_q), 32'h0);
    repeat (5) step();
    check("idle_out", 32'(out), 32'h0);
    check("idle_pstart", 32'(period_start), 32'h0);

    // Start running: interval cyc=0 is the first cycle with run=1.
    run = 1'b1;
    cyc = 0;
    #1;
    check("run_rise_pstart", 32'(period_start), 32'h1);
    check("run_rise_cnt", 32'(dut.pwm_cnt_q), 32'h0);
    step();
    check("pstart_one_cycle", 32'(period_start), 32'h0);

    // Commit at boundary.
    goto(130);
    check("cnt_at_130", 32'(dut.pwm_cnt_q), 32'd10);
    pulse_cfg(16'h00FF, 16'h0000, 8'd0);
    check("stage_pending", 32'(cfg_bus.cfg_pending), 32'h1);
    check("stage_no_apply", 32'(cfg_bus.cfg_applied), 32'h0);
    check("stage_out_old", 32'(out), 32'h0);
    goto(3327);
    check("pending_before_bnd", 32'(cfg_bus.cfg_pending), 32'h1);
    step();
    check("bnd_applied", 32'(cfg_bus.cfg_applied), 32'h1);
    check("bnd_pending_clr", 32'(cfg_bus.cfg_pending), 32'h0);
    check("bnd_pstart", 32'(period_start), 32'h1);
    check("bnd_out_lag", 32'(out), 32'h0);
    step();
    check("commit_out", 32'(out), 32'h00FF);
    check("applied_pulse_end", 32'(cfg_bus.cfg_applied), 32'h0);
    check("pstart_end", 32'(period_start), 32'h0);
    scan(4000, 16'h00FF, "commit_hold_a");

    // Duty 128 staged mid-period; enables already on so the fast path is a no-op.
    set_cfg(16'hFFFF, 16'hFFFF, 8'd128);
    scan(4001, 16'h00FF, "fast_mask_noop");
    cfg_bus.cfg_wr = 1'b0;
    scan(6655, 16'h00FF, "commit_hold_b");
    check("duty_pending", 32'(cfg_bus.cfg_pending), 32'h1);
    step();
    check("duty_applied", 32'(cfg_bus.cfg_applied), 32'h1);
    check("duty_out_lag", 32'(out), 32'h00FF);
    count_window(9984, hi, lo);
    check("duty128_high", 32'(hi), 32'd1664);
    check("duty128_low", 32'(lo), 32'd1664);

    // Duty 0 then duty 255.
    goto(10000);
    pulse_cfg(16'hFFFF, 16'hFFFF, 8'd0);
    goto(13312);
    scan(14000, 16'h0000, "duty0_a");
    set_cfg(16'hFFFF, 16'hFFFF, 8'd255);
    scan(14001, 16'h0000, "duty0_b");
    cfg_bus.cfg_wr = 1'b0;
    scan(16640, 16'h0000, "duty0_c");
    scan(19968, 16'hFFFF, "duty255_const");

    // Fast disable, delayed enable.
    goto(20000);
    pulse_cfg(16'h0F0F, 16'hFFFF, 8'd255);
    check("fast_disable", 32'(out), 32'h0F0F);
    goto(20100);
    pulse_cfg(16'hFFFF, 16'hFFFF, 8'd255);
    check("enable_waits", 32'(out), 32'h0F0F);
    scan(23295, 16'h0F0F, "enable_held");
    check("enable_pending", 32'(cfg_bus.cfg_pending), 32'h1);
    step();
    check("enable_applied", 32'(cfg_bus.cfg_applied), 32'h1);
    check("enable_out_lag", 32'(out), 32'h0F0F);
    step();
    check("enable_at_commit", 32'(out), 32'hFFFF);

    // Write coincident with the boundary.
    goto(26623);
    check("coll_pre_pending", 32'(cfg_bus.cfg_pending), 32'h0);
    pulse_cfg(16'hFFFF, 16'hFFFF, 8'd64);
    check("coll_applied", 32'(cfg_bus.cfg_applied), 32'h1);
    check("coll_pending", 32'(cfg_bus.cfg_pending), 32'h0);
    check("coll_pstart", 32'(period_start), 32'h1);
    goto(27456);
    check("coll_duty_last_hi", 32'(out), 32'hFFFF);
    step();
    check("coll_duty_fall", 32'(out), 32'h0000);

    // Two writes in one period: last wins.
    goto(27500);
    pulse_cfg(16'hFFFF, 16'hFFFF, 8'd32);
    goto(28000);
    pulse_cfg(16'hFFFF, 16'hFFFF, 8'd200);
    goto(29952);
    check("lww_applied", 32'(cfg_bus.cfg_applied), 32'h1);
    goto(30370);
    check("lww_not_first", 32'(out), 32'hFFFF);
    goto(32552);
    check("lww_last_hi", 32'(out), 32'hFFFF);
    step();
    check("lww_fall", 32'(out), 32'h0000);

    // run=0 with a pending config.
    goto(33000);
    pulse_cfg(16'h00FF, 16'h0000, 8'd0);
    check("stop_pending", 32'(cfg_bus.cfg_pending), 32'h1);
    goto(33100);
    run = 1'b0;
    step();
    check("stop_applied", 32'(cfg_bus.cfg_applied), 32'h1);
    check("stop_pending_clr", 32'(cfg_bus.cfg_pending), 32'h0);
    check("stop_out", 32'(out), 32'h0);
    check("stop_cnt", 32'(dut.pwm_cnt_q), 32'h0);
    step();
    check("stop_applied_end", 32'(cfg_bus.cfg_applied), 32'h0);
    check("stop_no_pstart", 32'(period_start), 32'h0);
    repeat (3) step();
    run = 1'b1;
    cyc = 0;
    #1;
    check("restart_pstart", 32'(period_start), 32'h1);
    check("restart_cnt", 32'(dut.pwm_cnt_q), 32'h0);
    step();
    check("restart_out", 32'(out), 32'h00FF);
    check("restart_pstart_end", 32'(period_start), 32'h0);
    goto(12);
    check("restart_pre_a", 32'(dut.pwm_cnt_q), 32'h0);
    step();
    check("restart_pre_b", 32'(dut.pwm_cnt_q), 32'h1);

    // Asynchronous reset mid-run drops staged config.
    goto(400);
    pulse_cfg(16'hFFFF, 16'hFFFF, 8'd100);
    check("pre_rst_pending", 32'(cfg_bus.cfg_pending), 32'h1);
    goto(500);
    rst = 1'b1;
    #1;
    check("midrst_out", 32'(out), 32'h0);
    check("midrst_pending", 32'(cfg_bus.cfg_pending), 32'h0);
    check("midrst_cnt", 32'(dut.pwm_cnt_q), 32'h0);
    check("midrst_pstart", 32'(period_start), 32'h0);
    run = 1'b0;
    step();
    step();
    rst = 1'b0;
    repeat (3) step();
    check("post_rst_out", 32'(out), 32'h0);
    check("post_rst_pending", 32'(cfg_bus.cfg_pending), 32'h0);
    check("post_rst_applied", 32'(cfg_bus.cfg_applied), 32'h0);
    check("post_rst_pstart", 32'(period_start), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
